// File: rtl/reg_write_queue.sv
// reg_write_queue
// ---------------------------------------------------------------------------
// Write-side front end of the pipeline register file. ALU results and load
// data are collected into a small in-order queue and retired one per cycle
// onto the register file's single write port. Entries still waiting in the
// queue are forwarded to the decode-stage read addresses, so a reader never
// sees a stale register.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   alu_valid/addr/data ALU write request;  alu_ready when >= 1 slot is free
//   ld_valid/addr/data  load write request; ld_ready  when >= 2 slots are free
//   write_reg/addr/data register-file write port (head of the queue)
//   read1, read2        decode-stage read addresses
//   fwd1_hit/data       youngest pending value for read1 (data 0 on a miss)
//   fwd2_hit/data       youngest pending value for read2 (data 0 on a miss)
//   count               occupied entries
// ---------------------------------------------------------------------------
module reg_write_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    output logic                         alu_ready,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    output logic                         ld_ready,
    output logic                         write_reg,
    output logic [ADDR_W-1:0]            write_addr,
    output logic [DATA_W-1:0]            write_data,
    input  logic [ADDR_W-1:0]            read1,
    input  logic [ADDR_W-1:0]            read2,
    output logic                         fwd1_hit,
    output logic [DATA_W-1:0]            fwd1_data,
    output logic                         fwd2_hit,
    output logic [DATA_W-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FREE1_LIMIT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FREE2_LIMIT = CNT_W'(DEPTH - 1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];

    logic              alu_enq;
    logic              ld_enq;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned      off);
        logic [PTR_W:0] sum;
        sum = {1'b0, p} + (PTR_W + 1)'(off);
        if (sum >= (PTR_W + 1)'(DEPTH)) begin
            sum = sum - (PTR_W + 1)'(DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Ready depends only on registered occupancy, never on the valids.
    assign alu_ready = (count_q < FREE1_LIMIT);
    assign ld_ready  = (count_q < FREE2_LIMIT);

    // r0 writes finish the handshake but are dropped here.
    assign alu_enq = alu_valid && alu_ready && (alu_addr != '0);
    assign ld_enq  = ld_valid  && ld_ready  && (ld_addr  != '0);

    // The register file always accepts, so a non-empty queue pops every edge.
    assign pop = (count_q != '0);

    always_comb begin
        head_d     = head_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_ptr     = tail_q;

        // ALU goes in first so a same-cycle load to the same register is the
        // younger entry and lands last.
        if (alu_enq) begin
            mem_addr_d[wr_ptr] = alu_addr;
            mem_data_d[wr_ptr] = alu_data;
            wr_ptr             = ptr_inc(wr_ptr);
        end
        if (ld_enq) begin
            mem_addr_d[wr_ptr] = ld_addr;
            mem_data_d[wr_ptr] = ld_data;
            wr_ptr             = ptr_inc(wr_ptr);
        end
        tail_d = wr_ptr;

        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        count_d = count_q + CNT_W'(alu_enq) + CNT_W'(ld_enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign count      = count_q;
    assign write_reg  = pop;
    assign write_addr = pop ? mem_addr_q[head_q] : '0;
    assign write_data = pop ? mem_data_q[head_q] : '0;

    // Walk occupied entries oldest to youngest; a later match overwrites an
    // earlier one, which gives youngest-first priority.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((read1 != '0) && (mem_addr_q[ptr_add(head_q, i)] == read1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data_q[ptr_add(head_q, i)];
                end
                if ((read2 != '0) && (mem_addr_q[ptr_add(head_q, i)] == read2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data_q[ptr_add(head_q, i)];
                end
            end
        end
    end

endmodule
